// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg: encodings shared by the UART receive and (future) transmit blocks.
package uart_pkg;

    // Parity mode encodings for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Frame state machine encodings
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Majority vote of three line samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
`timescale 1ns/1ps
// uart_bit_sampler: line synchronizer, bit-period counter and 3-sample
// majority vote around the middle of each bit period.
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int SAMPLE = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic restart,
    output logic rxs,
    output logic bit_end,
    output logic bit_strobe,
    output logic bit_value
);

    localparam int            CW       = $clog2(SAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(SAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(SAMPLE / 2);
    localparam logic [CW-1:0] CNT_S2   = CW'(SAMPLE / 2 + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          s0;
    logic          s1;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end

    assign rxs = sync[1];

    // Bit-period counter 0..SAMPLE-1, realigned to a start edge by restart
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           cnt <= '0;
        else if (restart || cnt == CNT_LAST) cnt <= '0;
        else                               cnt <= cnt + CW'(1);
    end

    // Hold the first two mid-bit samples; the third is taken live at the strobe
    always_ff @(posedge clk) begin
        if (cnt == CNT_S0) s0 <= rxs;
        if (cnt == CNT_S1) s1 <= rxs;
    end

    assign bit_strobe = (cnt == CNT_S2);
    assign bit_value  = maj3(s0, s1, rxs);
    assign bit_end    = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// uart_rx_param: parameterised UART receiver with a one-deep holding
// register, parity/frame error flags, break detection and overrun pulse.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int SAMPLE    = 104,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_rx,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);

    localparam int            CW        = $clog2(SAMPLE);
    localparam logic [CW-1:0] HI_LAST   = CW'(SAMPLE - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          state;
    uart_state_t          state_nx;
    logic                 rxs;
    logic                 bit_end;
    logic                 bit_strobe;
    logic                 bit_value;
    logic                 restart;
    logic [3:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 ferr_acc;
    logic                 brk_wait;
    logic [CW-1:0]        hi_cnt;
    logic                 frame_done;
    logic                 brk_det;
    logic                 is_break_bits;
    logic                 ferr_calc;

    // Odd parity wants an odd total of ones (data plus parity bit), even wants even
    function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY == PARITY_ODD)       return ~(^d ^ p);
        else if (PARITY == PARITY_EVEN) return ^d ^ p;
        else                            return 1'b0;
    endfunction

    uart_bit_sampler #(
        .SAMPLE(SAMPLE)
    ) u_sampler (
        .clk       (i_clk),
        .rst       (i_rst),
        .rx        (i_rx),
        .restart   (restart),
        .rxs       (rxs),
        .bit_end   (bit_end),
        .bit_strobe(bit_strobe),
        .bit_value (bit_value)
    );

    // A break is an all-zero frame up to and including the first stop bit
    assign is_break_bits = (shreg == '0) && ((PARITY == PARITY_NONE) || !par_bit) && !bit_value;
    assign ferr_calc     = ferr_acc | ~bit_value;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state and per-cycle control decisions
    always_comb begin
        state_nx   = state;
        restart    = 1'b0;
        frame_done = 1'b0;
        brk_det    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!brk_wait && !rxs) begin
                    restart  = 1'b1;
                    state_nx = ST_START;
                end
            end
            ST_START: begin
                if (bit_strobe && bit_value) state_nx = ST_IDLE;
                else if (bit_end)            state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (bit_strobe && bit_idx == DATA_LAST)
                    state_nx = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_strobe) state_nx = ST_STOP;
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    if (!stop_idx && is_break_bits) begin
                        brk_det  = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (stop_idx == STOP_LAST) begin
                        frame_done = 1'b1;
                        state_nx   = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Data-bit and stop-bit position counters, cleared outside their states
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            if (state != ST_DATA) bit_idx <= '0;
            else if (bit_strobe)  bit_idx <= bit_idx + 4'd1;
            if (state != ST_STOP) stop_idx <= 1'b0;
            else if (bit_strobe)  stop_idx <= 1'b1;
        end
    end

    // After a break, hold off new starts until the line has been high a full bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            brk_wait <= 1'b0;
            hi_cnt   <= '0;
        end else begin
            if (!rxs)                   hi_cnt <= '0;
            else if (hi_cnt != HI_LAST) hi_cnt <= hi_cnt + CW'(1);
            if (brk_det)                         brk_wait <= 1'b1;
            else if (rxs && hi_cnt == HI_LAST)   brk_wait <= 1'b0;
        end
    end

    // Shift data LSB first, capture the parity bit, accumulate stop-bit errors
    always_ff @(posedge i_clk) begin
        if (state == ST_DATA && bit_strobe)   shreg   <= {bit_value, shreg[DATA_BITS-1:1]};
        if (state == ST_PARITY && bit_strobe) par_bit <= bit_value;
        if (state != ST_STOP)                 ferr_acc <= 1'b0;
        else if (bit_strobe)                  ferr_acc <= ferr_acc | ~bit_value;
    end

    // Holding register: a new frame loads when the slot is free or being drained
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_break   <= brk_det;
            o_overrun <= frame_done && o_valid && !i_ready;
            if (frame_done && (!o_valid || i_ready)) begin
                o_data       <= shreg;
                o_parity_err <= parity_error(shreg, par_bit);
                o_frame_err  <= ferr_calc;
                o_valid      <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// tb_uart_rx_param: scoreboard bench driving an 8N1 and an 8E1 receiver.
module tb_uart_rx_param;
    import uart_pkg::*;

    localparam realtime CLK_HALF = 41.667;
    localparam realtime BIT_T    = 8681.0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx    [2];
    logic       ready [2];
    logic [7:0] data  [2];
    logic       valid [2];
    logic       perr  [2];
    logic       ferr  [2];
    logic       brk   [2];
    logic       ovr   [2];

    exp_t sbq [2][$];
    exp_t mon_e;
    int   exp_brk [2];
    int   exp_ovr [2];
    int   brk_cnt [2];
    int   ovr_cnt [2];
    int   vld_cycles [2];
    bit   hold [2];
    bit   rand_rdy;
    int   checks   = 0;
    int   failures = 0;

    always #(CLK_HALF) clk = ~clk;

    uart_rx_param #(.SAMPLE(104), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .i_clk(clk), .i_rst(rst), .i_rx(rx[0]), .i_ready(ready[0]),
        .o_data(data[0]), .o_valid(valid[0]), .o_parity_err(perr[0]),
        .o_frame_err(ferr[0]), .o_break(brk[0]), .o_overrun(ovr[0])
    );

    uart_rx_param #(.SAMPLE(104), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .i_clk(clk), .i_rst(rst), .i_rx(rx[1]), .i_ready(ready[1]),
        .o_data(data[1]), .o_valid(valid[1]), .o_parity_err(perr[1]),
        .o_frame_err(ferr[1]), .o_break(brk[1]), .o_overrun(ovr[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference model: decide what a frame should produce from its line contents
    task automatic model_frame(input int u, input logic [7:0] d, input logic pbit, input logic stop_lv);
        exp_t e;
        bit   has_par;
        int   ones;
        has_par = (u == 1);
        ones    = $countones(d) + ((has_par && pbit) ? 1 : 0);
        if (d == 8'h00 && (!has_par || !pbit) && !stop_lv) begin
            exp_brk[u]++;
        end else if (hold[u] && sbq[u].size() != 0) begin
            exp_ovr[u]++;
        end else begin
            e.data = d;
            e.perr = has_par && (ones % 2 != 0);
            e.ferr = !stop_lv;
            sbq[u].push_back(e);
        end
    endtask

    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                              input logic stop_lv, input int idle_bits);
        model_frame(u, d, pbit, stop_lv);
        rx[u] = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 8; i++) begin
            rx[u] = d[i];
            #(BIT_T);
        end
        if (u == 1) begin
            rx[u] = pbit;
            #(BIT_T);
        end
        rx[u] = stop_lv;
        #(BIT_T);
        rx[u] = 1'b1;
        for (int i = 0; i < idle_bits; i++) #(BIT_T);
    endtask

    task automatic set_ready(input int u, input logic v);
        @(posedge clk);
        #1;
        ready[u] = v;
    endtask

    task automatic wait_drain(input int u, input string name);
        int n;
        n = 0;
        while (sbq[u].size() != 0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check($sformatf("%s_drained_u%0d", name, u), sbq[u].size(), 0);
    endtask

    task automatic rand_frames(input int u);
        for (int k = 0; k < 12; k++) begin
            logic [7:0] d;
            logic       pb;
            logic       st;
            d  = 8'($urandom);
            pb = 1'($urandom);
            st = ($urandom_range(0, 4) != 0);
            if (d == 8'h00) st = 1'b1;
            send_frame(u, d, pb, st, 1 + $urandom_range(0, 2));
        end
    endtask

    // Monitor: count pulses and compare each accepted frame against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                if (valid[u]) vld_cycles[u]++;
                if (brk[u])   brk_cnt[u]++;
                if (ovr[u])   ovr_cnt[u]++;
                if (valid[u] && ready[u]) begin
                    if (sbq[u].size() == 0) begin
                        check($sformatf("unexpected_valid_u%0d", u), {24'd0, data[u]}, 32'hFFFF_FFFF);
                    end else begin
                        mon_e = sbq[u].pop_front();
                        check($sformatf("data_u%0d", u), data[u], mon_e.data);
                        check($sformatf("parity_err_u%0d_data%0h", u, mon_e.data), perr[u], mon_e.perr);
                        check($sformatf("frame_err_u%0d_data%0h", u, mon_e.data), ferr[u], mon_e.ferr);
                    end
                end
            end
        end
    end

    // Consumer that randomly throttles i_ready during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                ready[0] = 1'($urandom);
                ready[1] = 1'($urandom);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int b0;
        rx[0] = 1'b1; rx[1] = 1'b1;
        ready[0] = 1'b1; ready[1] = 1'b1;
        hold[0] = 1'b0; hold[1] = 1'b0;
        rand_rdy = 1'b0;
        for (int u = 0; u < 2; u++) begin
            exp_brk[u] = 0; exp_ovr[u] = 0; brk_cnt[u] = 0; ovr_cnt[u] = 0; vld_cycles[u] = 0;
        end

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid_u0", valid[0], 0);
        check("rst_data_u0", data[0], 0);
        check("rst_perr_u0", perr[0], 0);
        check("rst_ferr_u0", ferr[0], 0);
        check("rst_break_u0", brk[0], 0);
        check("rst_overrun_u0", ovr[0], 0);
        check("rst_valid_u1", valid[1], 0);
        check("rst_data_u1", data[1], 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);

        // 8N1 single frame, o_valid for exactly one cycle
        v0 = vld_cycles[0];
        send_frame(0, 8'h11, 1'b0, 1'b1, 1);
        wait_drain(0, "s1");
        repeat (10) @(posedge clk);
        check("s1_valid_cycles", vld_cycles[0] - v0, 1);

        // Even parity: correct then wrong parity bit
        send_frame(1, 8'hD6, 1'b1, 1'b1, 1);
        send_frame(1, 8'hD6, 1'b0, 1'b1, 1);
        wait_drain(1, "s2");

        // Short glitch must be rejected as a false start
        v0 = vld_cycles[0];
        rx[0] = 1'b0;
        repeat (40) @(posedge clk);
        rx[0] = 1'b1;
        #(2 * BIT_T);
        check("s3_state_idle", (dut_n.state == ST_IDLE), 1);
        check("s3_no_valid", vld_cycles[0] - v0, 0);
        send_frame(0, 8'hAA, 1'b0, 1'b1, 1);
        wait_drain(0, "s3");

        // Frame error, then a long break
        send_frame(0, 8'hE2, 1'b0, 1'b0, 1);
        wait_drain(0, "s4");
        v0 = vld_cycles[0];
        model_frame(0, 8'h00, 1'b0, 1'b0);
        rx[0] = 1'b0;
        #(12 * BIT_T);
        rx[0] = 1'b1;
        #(3 * BIT_T);
        check("s4_break_pulses", brk_cnt[0], exp_brk[0]);
        check("s4_break_no_valid", vld_cycles[0] - v0, 0);

        // Overrun while the consumer stalls
        hold[0] = 1'b1;
        set_ready(0, 1'b0);
        send_frame(0, 8'hAA, 1'b0, 1'b1, 0);
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1);
        check("s5_held_data", data[0], 8'hAA);
        check("s5_held_valid", valid[0], 1);
        check("s5_overrun_pulses", ovr_cnt[0], exp_ovr[0]);
        set_ready(0, 1'b1);
        wait_drain(0, "s5");
        repeat (2) @(posedge clk);
        #1;
        check("s5_valid_cleared", valid[0], 0);
        hold[0] = 1'b0;

        // Reset in the middle of data bit 4 of 0x55
        v0 = vld_cycles[0];
        b0 = brk_cnt[0];
        rx[0] = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            rx[0] = v0[0] ^ v0[0] ^ ((8'h55 >> i) & 1);
            #(BIT_T);
        end
        rx[0] = 1'b1;
        #(BIT_T / 2);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("s6_rst_valid", valid[0], 0);
        check("s6_rst_state_idle", (dut_n.state == ST_IDLE), 1);
        rst = 1'b0;
        #(2 * BIT_T);
        send_frame(0, 8'h33, 1'b0, 1'b1, 1);
        wait_drain(0, "s6");
        check("s6_only_one_frame", vld_cycles[0] - v0, 1);
        check("s6_no_break", brk_cnt[0] - b0, 0);

        // Random traffic on both receivers with a throttling consumer
        rand_rdy = 1'b1;
        fork
            rand_frames(0);
            rand_frames(1);
        join
        rand_rdy = 1'b0;
        set_ready(0, 1'b1);
        set_ready(1, 1'b1);
        wait_drain(0, "rand");
        wait_drain(1, "rand");

        check("final_break_u0", brk_cnt[0], exp_brk[0]);
        check("final_break_u1", brk_cnt[1], exp_brk[1]);
        check("final_overrun_u0", ovr_cnt[0], exp_ovr[0]);
        check("final_overrun_u1", ovr_cnt[1], exp_ovr[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high (ports i_clk, i_rst).
REQ-002 Parameter SAMPLE, default 104, SHALL be the clock cycles per bit (CLK_HZ / BAUDRATE), legal range 8..65535.
REQ-003 Parameter DATA_BITS, default 8, SHALL be the data bits per frame, legal range 5..9.
REQ-004 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, SHALL be the stop bits checked, legal values 1 or 2.
REQ-006 The ports SHALL be as follows.
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_rx  in  1  asynchronous serial line; idle high.
- i_ready  in  1  consumer accepts the held frame.
- o_data  out  DATA_BITS  received word, LSB first on the line.
- o_valid  out  1  held frame available.
- o_parity_err  out  1  parity mismatch for the held frame.
- o_frame_err  out  1  a stop bit sampled low for the held frame.
- o_break  out  1  one-cycle pulse: break detected.
- o_overrun  out  1  one-cycle pulse: completed frame dropped.

Function
REQ-007 i_rx SHALL pass through a 2-flop synchronizer before any use; all timing below is relative to the synchronized signal rxs.
REQ-008 Each bit SHALL be decided by a majority of 3 samples at bit-counter values SAMPLE/2-1, SAMPLE/2 and SAMPLE/2+1 (integer division); the counter SHALL run 0..SAMPLE-1 and wrap.
REQ-009 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
- IDLE->START on the first cycle rxs is low; the counter clears to 0.
- START->IDLE on a majority-1 (false start, no output); START->DATA on a majority-0 at counter SAMPLE-1.
- DATA SHALL shift DATA_BITS bits LSB first, then go to PARITY if PARITY!=0, else to STOP.
- STOP SHALL check STOP_BITS bits; the FSM SHALL enter IDLE in the cycle after the decision of the last stop bit (mid-bit), allowing resync for the next start edge.
REQ-010 Parity SHALL be computed over the DATA_BITS bits; odd mode expects the total count of 1s including the parity bit to be odd, even mode expects it to be even.
REQ-011 Frame completion (the last stop-bit decision) SHALL, when o_valid=0 or i_ready=1 in that cycle, load o_data, o_parity_err and o_frame_err, and set o_valid=1 on the next clock edge.
REQ-012 o_valid SHALL stay high, with its data and flags stable, until a cycle with o_valid=1 and i_ready=1; it SHALL clear after that edge unless a new frame loads in the same cycle, which has priority (o_valid stays 1 with the new data).
REQ-013 If a frame completes while o_valid=1 and i_ready=0, the new frame SHALL be discarded, the held frame SHALL stay unchanged, and o_overrun SHALL pulse for one cycle.
REQ-014 If all data bits, the parity bit (when present) and the first stop bit are decided 0, o_break SHALL pulse for one cycle, no frame SHALL be loaded, and the FSM SHALL wait in IDLE until rxs has been high for SAMPLE consecutive cycles before accepting a new start.
REQ-015 o_frame_err SHALL reflect any stop bit with a majority of 0 (excluding break); the frame is still delivered.

Reset
REQ-016 While i_rst=1 the block SHALL hold the following values; i_rst SHALL set these asynchronously, and release SHALL take effect on the next i_clk edge.
- FSM in IDLE; counters at 0.
- Synchronizer flops at 1.
- o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_break=0, o_overrun=0.
REQ-017 A reset asserted mid-frame SHALL abandon the frame with no output pulse; after release a full start bit SHALL be required.

Structure
REQ-018 The parity encodings (NONE/ODD/EVEN) and the FSM state encodings SHALL live in the shared package uart_pkg for reuse by a future uart_tx_param.
REQ-019 The synchronizer, the 3-sample majority and the bit counter SHALL be one sub-module, uart_bit_sampler, outputting bit_strobe and bit_value.

Verification
REQ-020 The bench SHALL use a 12 MHz clock, SAMPLE=104 and 8681 ns per bit, and SHALL cover these directed scenarios.
- 8N1, send 0x11, i_ready=1 -> o_data=0x11, o_valid high exactly one cycle, no error flags.
- PARITY=2, send 0xD6 with parity bit 1 -> no errors; send 0xD6 with parity bit 0 -> o_data=0xD6 with o_parity_err=1.
- 40-cycle low glitch on i_rx -> no o_valid, FSM back in IDLE; a following 0xAA is received correctly.
- Send 0xE2 with the stop bit low -> o_frame_err=1, o_data=0xE2; hold i_rx low for 12 bit times -> o_break pulses once, no o_valid.
- i_ready=0, send 0xAA then 0xFF back-to-back -> o_data stays 0xAA, o_overrun pulses once; i_ready=1 then clears o_valid.
- Assert i_rst during data bit 4 of 0x55, release, send 0x33 -> only 0x33 is delivered.
